// File: rtl/enc_pkg.sv
// Shared definitions for the quadrature encoder front end.
//   POS_WIDTH_DEF    default position counter width
//   DIR_FWD/DIR_REV  values carried on the dir output
//   gray_t           {A,B} line state; forward order is 00 -> 10 -> 11 -> 01 -> 00
//   gray_next_fwd    the state one forward step after the given one
package enc_pkg;

    localparam int unsigned POS_WIDTH_DEF = 25;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    typedef enum logic [1:0] {
        AB_00 = 2'b00,
        AB_10 = 2'b10,
        AB_11 = 2'b11,
        AB_01 = 2'b01
    } gray_t;

    function automatic gray_t gray_next_fwd(input gray_t s);
        case (s)
            AB_00:   return AB_10;
            AB_10:   return AB_11;
            AB_11:   return AB_01;
            default: return AB_00;
        endcase
    endfunction

endpackage

// File: rtl/enc_quad_decoder_if.sv
// Host/encoder-side signal bundle of one decoder channel.
//   a_in, b_in               raw encoder lines (asynchronous)
//   preload_en, preload_val  load a new position value
//   err_clr                  clear the sticky quad_err flag
//   position, dir            accumulated count and last step direction
//   a_up/a_dn/b_up/b_dn      one-cycle edge strobes of legal steps
//   quad_err                 sticky illegal-transition flag
// master drives the inputs of the decoder, slave is the decoder itself.
interface enc_quad_decoder_if #(
    parameter int unsigned POS_WIDTH = 25
);
    logic                 a_in;
    logic                 b_in;
    logic                 preload_en;
    logic [POS_WIDTH-1:0] preload_val;
    logic                 err_clr;
    logic [POS_WIDTH-1:0] position;
    logic                 dir;
    logic                 a_up;
    logic                 a_dn;
    logic                 b_up;
    logic                 b_dn;
    logic                 quad_err;

    modport master (
        output a_in, b_in, preload_en, preload_val, err_clr,
        input  position, dir, a_up, a_dn, b_up, b_dn, quad_err
    );

    modport slave (
        input  a_in, b_in, preload_en, preload_val, err_clr,
        output position, dir, a_up, a_dn, b_up, b_dn, quad_err
    );
endinterface

// File: rtl/enc_glitch_filter.sv
// Synchroniser plus persistence filter for one raw encoder line.
//   clk, reset  system clock, synchronous active-high reset
//   raw         asynchronous input line
//   enable      0 holds the filter (counter parked at 0, level frozen)
//   load        copy the synchroniser output straight into the filtered level
//   sync        last synchroniser stage
//   filt        filtered level; changes only after FILT_LEN consecutive
//               samples that disagree with it
module enc_glitch_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic enable,
    input  logic load,
    output logic sync,
    output logic filt
);
    localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   filt_q;

    assign sync = sync_q[SYNC_STAGES-1];
    assign filt = filt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (load) begin
                filt_q <= sync;
                cnt_q  <= '0;
            end else if (!enable || (sync == filt_q)) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILT_LEN - 1)) begin
                // this sample is the FILT_LEN-th mismatch in a row
                filt_q <= ~filt_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end
endmodule

// File: rtl/enc_quad_decoder.sv
// Quadrature decoder for one encoder channel: synchronises and filters A/B,
// decodes legal Gray-code steps into a wrapping signed position and a
// direction bit, emits one-cycle edge strobes and a sticky error on
// transitions where both filtered lines moved at once.
//   clk, reset  system clock, synchronous active-high reset
//   bus         enc_quad_decoder_if slave (raw lines, preload, err_clr,
//               position/dir/strobes/quad_err)
module enc_quad_decoder
    import enc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned POS_WIDTH   = POS_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    enc_quad_decoder_if.slave   bus
);
    localparam int unsigned FW = $clog2(SYNC_STAGES + 1);

    logic                 init_q;
    logic [FW-1:0]        fill_q;
    logic                 init_load;
    logic                 sync_a, sync_b;
    logic                 filt_a, filt_b;
    gray_t                prev_q;
    gray_t                cur;
    logic                 step_fwd, step_rev, illegal;
    logic                 a_changed;
    logic [POS_WIDTH-1:0] pos_q;
    logic                 dir_q, err_q;
    logic                 a_up_q, a_dn_q, b_up_q, b_dn_q;

    // After reset the filters stay frozen until the sync chain holds real
    // samples, then both filtered levels and the decoder history are loaded
    // from it in one edge so start-up never looks like a step.
    assign init_load = init_q && (fill_q == FW'(SYNC_STAGES));

    enc_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
        .clk    (clk),
        .reset  (reset),
        .raw    (bus.a_in),
        .enable (!init_q),
        .load   (init_load),
        .sync   (sync_a),
        .filt   (filt_a)
    );

    enc_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
        .clk    (clk),
        .reset  (reset),
        .raw    (bus.b_in),
        .enable (!init_q),
        .load   (init_load),
        .sync   (sync_b),
        .filt   (filt_b)
    );

    assign cur       = gray_t'({filt_a, filt_b});
    assign a_changed = filt_a ^ prev_q[1];

    always_comb begin
        step_fwd = 1'b0;
        step_rev = 1'b0;
        illegal  = 1'b0;
        if (!init_q && (cur != prev_q)) begin
            if (cur == gray_next_fwd(prev_q)) begin
                step_fwd = 1'b1;
            end else if (prev_q == gray_next_fwd(cur)) begin
                step_rev = 1'b1;
            end else begin
                illegal = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            init_q <= 1'b1;
            fill_q <= '0;
            prev_q <= AB_00;
            pos_q  <= '0;
            dir_q  <= DIR_REV;
            err_q  <= 1'b0;
            a_up_q <= 1'b0;
            a_dn_q <= 1'b0;
            b_up_q <= 1'b0;
            b_dn_q <= 1'b0;
        end else begin
            a_up_q <= 1'b0;
            a_dn_q <= 1'b0;
            b_up_q <= 1'b0;
            b_dn_q <= 1'b0;

            if (init_q) begin
                if (init_load) begin
                    init_q <= 1'b0;
                    prev_q <= gray_t'({sync_a, sync_b});
                end else begin
                    fill_q <= fill_q + FW'(1);
                end
            end else begin
                prev_q <= cur;
            end

            if (step_fwd || step_rev) begin
                dir_q <= step_fwd ? DIR_FWD : DIR_REV;
                pos_q <= step_fwd ? pos_q + POS_WIDTH'(1) : pos_q - POS_WIDTH'(1);
                if (a_changed) begin
                    a_up_q <= filt_a;
                    a_dn_q <= ~filt_a;
                end else begin
                    b_up_q <= filt_b;
                    b_dn_q <= ~filt_b;
                end
            end

            // preload replaces only the count; dir/strobes of a coincident step stand
            if (bus.preload_en) begin
                pos_q <= bus.preload_val;
            end

            if (illegal) begin
                err_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.position = pos_q;
    assign bus.dir      = dir_q;
    assign bus.quad_err = err_q;
    assign bus.a_up     = a_up_q;
    assign bus.a_dn     = a_dn_q;
    assign bus.b_up     = b_up_q;
    assign bus.b_dn     = b_dn_q;
endmodule
